fib_mem_ctrl: RTL and testbench

Memory initiator that drives the 8-bit single-port RAM of the Fibonacci processor: on a start pulse it writes successive Fibonacci terms (0, 1, 1, 2, …) into consecutive RAM addresses, then optionally reads every written location back and checks it. It sits between the processor control logic, which supplies `start` and monitors the status flags, and the RAM port (`wr_en`, `addr`, `datain`, `dataout`). The RAM writes on the falling clock edge and reads combinationally.

---
 rtl/fib_mem_ctrl_if.sv | 22 ++
 rtl/fib_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_fib_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_mem_ctrl_if.sv
// fib_mem_ctrl_if: RAM port bundle between the Fibonacci
// memory initiator (master) and the single-port RAM (slave).
interface fib_mem_ctrl_if;
  logic       wr_en;
  logic [7:0] addr;
  logic [7:0] datain;
  logic [7:0] dataout;

  modport master (
    output wr_en,
    output addr,
    output datain,
    input  dataout
  );

  modport slave (
    input  wr_en,
    input  addr,
    input  datain,
    output dataout
  );
endinterface

// File: rtl/fib_mem_ctrl.sv
// fib_mem_ctrl: writes Fibonacci terms into RAM, optional readback.
// Define FIB_VERIFY_EN to build the VERIFY pass and the err flag.
module fib_mem_ctrl #(
  parameter int unsigned COUNT     = 14,
  parameter logic [7:0]  BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  fib_mem_ctrl_if.master mem,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       err,
  output logic [7:0] last_term
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  localparam logic [8:0] LAST = 9'(COUNT - 1);

  state_t     state;
  state_t     state_nx;
  logic [8:0] a;
  logic [8:0] b;
  logic [8:0] k;
  logic       wr_last;
  logic       wr_stop;

  // b holds the next term; b[8] means it no longer fits
  assign wr_last = (k == LAST);
  assign wr_stop = wr_last | b[8];

`ifdef FIB_VERIFY_EN
  logic [8:0] wcnt;
  logic       vf_last;

  assign vf_last = (k == wcnt - 9'd1);
`else
  logic unused_dout;

  assign err         = 1'b0;
  assign unused_dout = ^mem.dataout;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and RAM/status outputs
  always_comb begin
    state_nx   = state;
    mem.wr_en  = 1'b0;
    mem.addr   = 8'h00;
    mem.datain = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        mem.wr_en  = 1'b1;
        mem.addr   = BASE_ADDR + k[7:0];
        mem.datain = a[7:0];
`ifdef FIB_VERIFY_EN
        if (wr_stop) state_nx = VERIFY;
`else
        if (wr_stop) state_nx = DONE;
`endif
      end
      VERIFY: begin
`ifdef FIB_VERIFY_EN
        busy     = 1'b1;
        mem.addr = BASE_ADDR + k[7:0];
        if (vf_last) state_nx = DONE;
`else
        state_nx = IDLE;
`endif
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // term generator, index and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= 9'd0;
      b         <= 9'd0;
      k         <= 9'd0;
      ovf       <= 1'b0;
      last_term <= 8'h00;
`ifdef FIB_VERIFY_EN
      err       <= 1'b0;
      wcnt      <= 9'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a         <= 9'd0;
            b         <= 9'd1;
            k         <= 9'd0;
            ovf       <= 1'b0;
            last_term <= 8'h00;
`ifdef FIB_VERIFY_EN
            err       <= 1'b0;
`endif
          end
        end
        WRITE: begin
          last_term <= a[7:0];
          a         <= b;
          b         <= a + b;
          k         <= k + 9'd1;
          if (!wr_last && b[8]) ovf <= 1'b1;
`ifdef FIB_VERIFY_EN
          if (wr_stop) begin
            wcnt <= k + 9'd1;
            a    <= 9'd0;
            b    <= 9'd1;
            k    <= 9'd0;
          end
`endif
        end
`ifdef FIB_VERIFY_EN
        VERIFY: begin
          if (mem.dataout != a[7:0]) err <= 1'b1;
          a <= b;
          b <= a + b;
          k <= k + 9'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_mem_ctrl.sv
// tb_fib_mem_ctrl: directed bench for fib_mem_ctrl, three
// instances (COUNT/BASE 14/0, 20/0, 10/250) on RAM models.
module tb_fib_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st0, st1, st2;
  logic b0, b1, b2;
  logic d0, d1, d2;
  logic o0, o1, o2;
  logic e0, e1, e2;
  logic [7:0] lt0, lt1, lt2;
  logic inj;
  logic fill;

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic [7:0] ram2 [256];
  int wc0 = 0;
  int wc1 = 0;
  int wc2 = 0;

  int nvec = 0;
  int nerr = 0;

  int fib [14] = '{0, 1, 1, 2, 3, 5, 8, 13,
                   21, 34, 55, 89, 144, 233};

`ifdef FIB_VERIFY_EN
  localparam int VF = 1;
`else
  localparam int VF = 0;
`endif

  fib_mem_ctrl_if m0 ();
  fib_mem_ctrl_if m1 ();
  fib_mem_ctrl_if m2 ();

  fib_mem_ctrl #(.COUNT(14), .BASE_ADDR(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .mem(m0),
    .busy(b0), .done(d0), .ovf(o0), .err(e0),
    .last_term(lt0)
  );

  fib_mem_ctrl #(.COUNT(20), .BASE_ADDR(8'h00)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .mem(m1),
    .busy(b1), .done(d1), .ovf(o1), .err(e1),
    .last_term(lt1)
  );

  fib_mem_ctrl #(.COUNT(10), .BASE_ADDR(8'd250)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .mem(m2),
    .busy(b2), .done(d2), .ovf(o2), .err(e2),
    .last_term(lt2)
  );

  always #5 clk = ~clk;

  // combinational RAM reads; u0 can be fed a bad byte at addr 5
  assign m0.dataout =
    (inj && b0 && !m0.wr_en && m0.addr == 8'd5) ?
    8'hFF : ram0[m0.addr];
  assign m1.dataout = ram1[m1.addr];
  assign m2.dataout = ram2[m2.addr];

  // falling-edge RAM writes, with a bulk fill to a marker byte
  always @(negedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) begin
        ram0[i] <= 8'hA5;
        ram1[i] <= 8'hA5;
        ram2[i] <= 8'hA5;
      end
    end else begin
      if (m0.wr_en) begin
        ram0[m0.addr] <= m0.datain;
        wc0 <= wc0 + 1;
      end
      if (m1.wr_en) begin
        ram1[m1.addr] <= m1.datain;
        wc1 <= wc1 + 1;
      end
      if (m2.wr_en) begin
        ram2[m2.addr] <= m2.datain;
        wc2 <= wc2 + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_fill();
    @(negedge clk);
    fill = 1'b1;
    @(negedge clk);
    #1 fill = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int id);
    if (id == 0) return d0;
    if (id == 1) return d1;
    return d2;
  endfunction

  // start pulse at E0; cyc = 1 at E0, +1 per edge until done
  task automatic go(input int id, output int cyc);
    if (id == 0) st0 = 1'b1;
    if (id == 1) st1 = 1'b1;
    if (id == 2) st2 = 1'b1;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
    cyc = 1;
    while (!done_of(id) && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done_of(id)) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int base;
    int nd;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
    inj = 1'b0;
    fill = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", m0.wr_en, 0);
    chk("rst_addr", m0.addr, 0);
    chk("rst_datain", m0.datain, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_ovf", o0, 0);
    chk("rst_err", e0, 0);
    chk("rst_last", lt0, 0);
    rst_n = 1'b1;
    do_fill();

    base = wc0;
    go(0, cyc);
    chk("c14_latency", cyc, 15 + VF * 14);
    chk("c14_last", lt0, 233);
    chk("c14_ovf", o0, 0);
    chk("c14_err", e0, 0);
    chk("c14_writes", wc0 - base, 14);
    for (int i = 0; i < 14; i++)
      chk("c14_ram", ram0[i], fib[i]);
    chk("c14_ram14", ram0[14], 8'hA5);
    @(posedge clk);
    #1;
    chk("c14_done_pulse", d0, 0);
    chk("c14_idle_busy", b0, 0);
    chk("c14_hold_last", lt0, 233);

    base = wc1;
    go(1, cyc);
    chk("c20_latency", cyc, 15 + VF * 14);
    chk("c20_writes", wc1 - base, 14);
    chk("c20_ram13", ram1[13], 233);
    chk("c20_ram14", ram1[14], 8'hA5);
    chk("c20_ovf", o1, 1);
    chk("c20_last", lt1, 233);
    chk("c20_err", e1, 0);

    base = wc2;
    go(2, cyc);
    chk("wrap_latency", cyc, 11 + VF * 10);
    chk("wrap_writes", wc2 - base, 10);
    for (int i = 0; i < 6; i++)
      chk("wrap_ram_hi", ram2[250 + i], fib[i]);
    for (int i = 0; i < 4; i++)
      chk("wrap_ram_lo", ram2[i], fib[6 + i]);
    chk("wrap_ram4", ram2[4], 8'hA5);
    chk("wrap_ram249", ram2[249], 8'hA5);
    chk("wrap_err", e2, 0);
    chk("wrap_ovf", o2, 0);
    chk("wrap_last", lt2, 34);

    inj = 1'b1;
    go(0, cyc);
    chk("inj_err", e0, VF);
    repeat (3) @(posedge clk);
    #1;
    chk("inj_err_hold", e0, VF);
    inj = 1'b0;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    chk("inj_err_clear", e0, 0);
    nd = 0;
    while (!d0 && nd < 100) begin
      @(posedge clk);
      #1;
      nd++;
    end
    chk("rerun_done", d0, 1);
    chk("rerun_err", e0, 0);

    do_fill();
    base = wc0;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      if (d0) nd++;
      @(posedge clk);
      #1;
    end
    chk("ign_done_count", nd, 1);
    chk("ign_writes", wc0 - base, 14);
    chk("ign_busy", b0, 0);

    do_fill();
    base = wc0;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_writing", m0.wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", m0.wr_en, 0);
    chk("mid_rst_busy", b0, 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (d0) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    chk("mid_rst_writes", wc0 - base, 5);
    chk("mid_rst_ram4", ram0[4], 3);
    chk("mid_rst_ram5", ram0[5], 8'hA5);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    go(0, cyc);
    chk("post_rst_latency", cyc, 15 + VF * 14);
    chk("post_rst_last", lt0, 233);
    chk("post_rst_ram13", ram0[13], 233);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
